// File: rtl/dac_update_scheduler_if.sv
// Producer/driver-side bus of the DAC update scheduler.
// master = environment (producers, route control, driver busy); slave = scheduler.
interface dac_update_scheduler_if #(parameter int NUM_SRC = 4);
  logic [NUM_SRC*16-1:0] src_data;
  logic [NUM_SRC-1:0]    src_valid;
  logic [7:0]            route;
  logic                  route_update;
  logic                  force_midscale;
  logic                  dac_busy;
  logic                  dac_start;
  logic [63:0]           dac_data;
  logic [15:0]           frame_count;
  logic [7:0]            drop_count;
  logic                  timeout_err;

  modport master (
    output src_data, src_valid, route, route_update, force_midscale, dac_busy,
    input  dac_start, dac_data, frame_count, drop_count, timeout_err
  );
  modport slave (
    input  src_data, src_valid, route, route_update, force_midscale, dac_busy,
    output dac_start, dac_data, frame_count, drop_count, timeout_err
  );
endinterface

// File: rtl/dac_update_scheduler.sv
// Routes producer samples to four AD5541A channels and paces driver start pulses.
// Optional DAC_SLEW_LIMIT_EN: per-frame step limit of MAX_STEP per channel.
module dac_sched_lane #(
  parameter logic [15:0] MAX_STEP = 16'h0400
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      sel,
  input  logic [3:0]      src_v,
  input  logic [3:0][15:0] src_d,
  input  logic            launch,
  input  logic            force_mid,
  output logic            dirty,
  output logic            drop,
  output logic [15:0]     dac_word
);
  logic        hit;
  logic        keep_dirty;
  logic [15:0] pending;
  logic [15:0] next_word;

  assign hit  = src_v[sel];
  // a sample arriving on the launch cycle re-arms dirty instead of counting as a drop
  assign drop = hit & dirty & ~launch;

`ifdef DAC_SLEW_LIMIT_EN
  logic [15:0]        prev;
  logic [15:0]        step;
  logic signed [16:0] diff;
  logic signed [16:0] lim;
  logic signed [16:0] lim_max;

  always_comb begin
    prev    = dac_word ^ 16'h8000;
    lim_max = $signed({1'b0, MAX_STEP});
    diff    = $signed({pending[15], pending}) - $signed({prev[15], prev});
    if (diff > lim_max)       lim = lim_max;
    else if (diff < -lim_max) lim = -lim_max;
    else                      lim = diff;
    step       = prev + lim[15:0];
    next_word  = force_mid ? 16'h8000 : (step ^ 16'h8000);
    keep_dirty = dirty && !force_mid && (step != pending);
  end
`else
  logic unused_max_step;
  assign unused_max_step = ^MAX_STEP;
  assign next_word  = force_mid ? 16'h8000 : (pending ^ 16'h8000);
  assign keep_dirty = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      dirty    <= 1'b0;
      dac_word <= 16'h8000;
    end else begin
      if (launch) dac_word <= next_word;
      if (hit) begin
        pending <= src_d[sel];
        dirty   <= 1'b1;
      end else if (launch) begin
        dirty <= keep_dirty;
      end
    end
  end
endmodule

module dac_update_scheduler #(
  parameter int          NUM_SRC      = 4,
  parameter int          MIN_PERIOD   = 50,
  parameter int          BUSY_TIMEOUT = 4,
  parameter logic [15:0] MAX_STEP     = 16'h0400
) (
  input logic                  clk,
  input logic                  reset_n,
  dac_update_scheduler_if.slave bus
);
  localparam int NUM_CH = 4;
  localparam int HW     = $clog2(MIN_PERIOD);
  localparam int TW     = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, BUSY, HOLDOFF} state_t;

  state_t                     state_q, state_d;
  logic [HW-1:0]              holdoff_q;
  logic [TW-1:0]              tmo_q;
  logic [7:0]                 route_act, route_pend;
  logic                       route_pend_vld;
  logic                       launch, tmo_hit;
  logic [NUM_CH-1:0]          dirty, drop;
  logic [NUM_CH-1:0][15:0]    dac_word;
  logic [3:0]                 src_v4;
  logic [3:0][15:0]           src_d4;
  logic [2:0]                 ndrop;
  logic [8:0]                 drop_sum;
  logic                       dac_start_q, tmo_err_q;
  logic [15:0]                frame_q;
  logic [7:0]                 drop_q;

  // sources beyond NUM_SRC read as never-valid, so such routes never dirty a channel
  always_comb begin
    src_v4 = '0;
    src_d4 = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src_v4[s] = bus.src_valid[s];
      src_d4[s] = bus.src_data[16*s +: 16];
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    dac_sched_lane #(.MAX_STEP(MAX_STEP)) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .sel      (route_act[2*k +: 2]),
      .src_v    (src_v4),
      .src_d    (src_d4),
      .launch   (launch),
      .force_mid(bus.force_midscale),
      .dirty    (dirty[k]),
      .drop     (drop[k]),
      .dac_word (dac_word[k])
    );
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE: if (holdoff_q == '0 && (|dirty || bus.force_midscale)) begin
        launch  = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.dac_busy) state_d = BUSY;
        else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_d = HOLDOFF;
        end
      end
      BUSY:    if (!bus.dac_busy) state_d = HOLDOFF;
      HOLDOFF: if (holdoff_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ndrop = '0;
    for (int k = 0; k < NUM_CH; k++) ndrop = ndrop + 3'(drop[k]);
    drop_sum = {1'b0, drop_q} + 9'(ndrop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      holdoff_q      <= '0;
      tmo_q          <= '0;
      route_act      <= 8'b11_10_01_00;
      route_pend     <= 8'b11_10_01_00;
      route_pend_vld <= 1'b0;
      dac_start_q    <= 1'b0;
      frame_q        <= '0;
      drop_q         <= '0;
      tmo_err_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dac_start_q <= launch;
      frame_q     <= frame_q + 16'(launch);
      drop_q      <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      tmo_err_q   <= tmo_err_q | tmo_hit;
      tmo_q       <= (state_q == WAIT_BUSY) ? tmo_q + 1'b1 : '0;
      if (launch)                holdoff_q <= HW'(MIN_PERIOD - 1);
      else if (holdoff_q != '0)  holdoff_q <= holdoff_q - 1'b1;
      // a fresh route_update overrides the clear so the newest table is applied next IDLE
      if (state_q == IDLE && route_pend_vld) begin
        route_act      <= route_pend;
        route_pend_vld <= 1'b0;
      end
      if (bus.route_update) begin
        route_pend     <= bus.route;
        route_pend_vld <= 1'b1;
      end
    end
  end

  assign bus.dac_start   = dac_start_q;
  assign bus.dac_data    = dac_word;
  assign bus.frame_count = frame_q;
  assign bus.drop_count  = drop_q;
  assign bus.timeout_err = tmo_err_q;
endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed-sequence bench with random data for dac_update_scheduler.
// A transaction-level model tracks latest samples, dirtiness, drops and frames per channel.
module tb_dac_update_scheduler;
  localparam int NUM_SRC    = 4;
  localparam int MIN_PERIOD = 50;
  localparam int BUSY_LEN   = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;

  dac_update_scheduler_if #(.NUM_SRC(NUM_SRC)) bus();

  dac_update_scheduler #(
    .NUM_SRC(NUM_SRC), .MIN_PERIOD(MIN_PERIOD), .BUSY_TIMEOUT(4), .MAX_STEP(16'h0400)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_pend [4];
  bit          m_dirty[4];
  logic [1:0]  m_route[4];
  int          m_drops  = 0;
  int          m_frames = 0;

  function automatic void m_capture(input logic [3:0] m, input logic [63:0] d);
    for (int k = 0; k < 4; k++) begin
      int s;
      s = int'(m_route[k]);
      if (s < NUM_SRC && m[s]) begin
        if (m_dirty[k] && m_drops < 255) m_drops++;
        m_pend[k]  = d[16*s +: 16];
        m_dirty[k] = 1'b1;
      end
    end
  endfunction

  function automatic logic [63:0] m_launch(input bit frc);
    logic [63:0] out;
    m_frames++;
    for (int k = 0; k < 4; k++) begin
      out[16*k +: 16] = frc ? 16'h8000 : (m_pend[k] ^ 16'h8000);
      m_dirty[k] = 1'b0;
    end
    return out;
  endfunction

  // ---------------- driver model and monitor ----------------
  bit drv_en = 1'b1;
  int busy_cnt = 0;
  initial begin
    bus.dac_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) bus.dac_busy = 1'b0;
      end
      if (bus.dac_start && drv_en) begin
        busy_cnt     = BUSY_LEN;
        bus.dac_busy = 1'b1;
      end
    end
  end

  int   cyc = 0;
  int   last_start = -1;
  int   mon_starts = 0;
  logic busy_at_edge = 1'b0;
  always @(posedge clk) begin
    cyc          <= cyc + 1;
    busy_at_edge <= bus.dac_busy;
  end
  always @(negedge clk) begin
    if (reset_n && bus.dac_start) begin
      mon_starts++;
      if (last_start >= 0) check("start_spacing", 64'(cyc - last_start >= MIN_PERIOD), 64'd1);
      check("start_while_busy", 64'(busy_at_edge), 64'd0);
      last_start = cyc;
    end
  end

  initial begin
    repeat (20000) @(negedge clk);
    $display("FAIL watchdog: simulation did not complete, observed cycle %0d required < 20000", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic strobe(input logic [3:0] m, input logic [63:0] d);
    bus.src_data  = d;
    bus.src_valid = m;
    m_capture(m, d);
    @(negedge clk);
    bus.src_valid = '0;
  endtask

  task automatic wait_start(input string tag, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.dac_start) begin
        ok = 1'b1;
        break;
      end
    end
    n_assert++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s: dac_start observed 0 expected 1 within %0d cycles", tag, budget);
    end
  endtask

  task automatic expect_launch(input string tag, input bit frc);
    bit ok;
    logic [63:0] exp;
    wait_start(tag, 200, ok);
    if (ok) begin
      exp = m_launch(frc);
      check({tag, "_data"},   bus.dac_data, exp);
      check({tag, "_frames"}, 64'(bus.frame_count), 64'(m_frames));
      check({tag, "_drops"},  64'(bus.drop_count),  64'(m_drops));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] rd;
    bit ok;
    bus.src_data       = '0;
    bus.src_valid      = '0;
    bus.route          = 8'b11_10_01_00;
    bus.route_update   = 1'b0;
    bus.force_midscale = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_pend[k]  = '0;
      m_dirty[k] = 1'b0;
      m_route[k] = 2'(k);
    end

    repeat (3) @(negedge clk);
    check("rst_data",    bus.dac_data, {4{16'h8000}});
    check("rst_start",   64'(bus.dac_start), 64'd0);
    check("rst_frames",  64'(bus.frame_count), 64'd0);
    check("rst_drops",   64'(bus.drop_count), 64'd0);
    check("rst_timeout", 64'(bus.timeout_err), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

`ifdef DAC_SLEW_LIMIT_EN
    strobe(4'b0001, {48'h0, 16'h1000});
    for (int f = 1; f <= 4; f++) begin
      logic [15:0] exp_w;
      exp_w = 16'h8000 + 16'(f * 16'h0400);
      wait_start("slew_launch", 200, ok);
      if (ok) check("slew_ch0", 64'(bus.dac_data[15:0]), 64'(exp_w));
    end
    ok = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus.dac_start) ok = 1'b1;
    end
    check("slew_quiet", 64'(ok), 64'd0);
    check("slew_frames", 64'(bus.frame_count), 64'd4);
`else
    // launch latency: strobe at n, start and data at n+2
    strobe(4'b0001, {$urandom, 16'h5A5A, 16'h1234});
    check("lat_n1_start", 64'(bus.dac_start), 64'd0);
    @(negedge clk);
    check("lat_start", 64'(bus.dac_start), 64'd1);
    check("lat_data", bus.dac_data, m_launch(1'b0));
    check("lat_frames", 64'(bus.frame_count), 64'd1);
    @(negedge clk);
    check("lat_pulse_end", 64'(bus.dac_start), 64'd0);

    // three strobes while busy: next frame carries the third, two drops
    for (int i = 0; i < 3; i++) begin
      rd = {$urandom, $urandom};
      strobe(4'b0001, rd);
      repeat (4) @(negedge clk);
    end
    expect_launch("drop", 1'b0);

    // driver never answers
    repeat (80) @(negedge clk);
    drv_en = 1'b0;
    rd = {$urandom, $urandom};
    strobe(4'b0101, rd);
    expect_launch("to_launch", 1'b0);
    repeat (3) @(negedge clk);
    check("to_before", 64'(bus.timeout_err), 64'd0);
    @(negedge clk);
    check("to_after", 64'(bus.timeout_err), 64'd1);
    rd = {$urandom, $urandom};
    strobe(4'b0010, rd);
    expect_launch("to_relaunch", 1'b0);
    drv_en = 1'b1;
    repeat (80) @(negedge clk);

    // route change requested while BUSY takes effect only after the next IDLE
    rd = {$urandom, $urandom};
    strobe(4'b0001, rd);
    expect_launch("rt_first", 1'b0);
    repeat (3) @(negedge clk);
    check("rt_busy", 64'(bus.dac_busy), 64'd1);
    bus.route = {2'd1, 2'd2, 2'd1, 2'd0};
    bus.route_update = 1'b1;
    @(negedge clk);
    bus.route_update = 1'b0;
    rd = {$urandom, $urandom};
    strobe(4'b0010, rd);
    expect_launch("rt_old", 1'b0);
    m_route[3] = 2'd1;
    repeat (5) @(negedge clk);
    rd = {$urandom, $urandom};
    rd[31:16] = 16'hFFFF;
    strobe(4'b0010, rd);
    expect_launch("rt_new", 1'b0);
    check("rt_ch3", 64'(bus.dac_data[63:48]), 64'h7FFF);

    // force_midscale: midscale frames, even with nothing dirty
    rd = {$urandom, $urandom};
    rd[31:16] = 16'h7FFF;
    bus.force_midscale = 1'b1;
    strobe(4'b0010, rd);
    expect_launch("force1", 1'b1);
    expect_launch("force2", 1'b1);
    @(negedge clk);
    bus.force_midscale = 1'b0;
    repeat (80) @(negedge clk);
    check("force_quiet", 64'(bus.frame_count), 64'(m_frames));
    rd = {$urandom, $urandom};
    strobe(4'b0001, rd);
    expect_launch("post_force", 1'b0);
    repeat (80) @(negedge clk);

    // sample on the launch cycle rides the next frame without a drop
    rd = {$urandom, $urandom};
    bus.src_data = rd; bus.src_valid = 4'b0001;
    m_capture(4'b0001, rd);
    @(negedge clk);
    rd = {$urandom, $urandom};
    bus.src_data = rd;
    @(negedge clk);
    bus.src_valid = '0;
    check("sim_start", 64'(bus.dac_start), 64'd1);
    check("sim_data", bus.dac_data, m_launch(1'b0));
    m_capture(4'b0001, rd);
    expect_launch("sim_next", 1'b0);

    // random strobe bursts between launches
    for (int it = 0; it < 6; it++) begin
      int nb;
      repeat (3) @(negedge clk);
      nb = int'($urandom_range(1, 5));
      for (int j = 0; j < nb; j++) begin
        rd = {$urandom, $urandom};
        strobe(4'($urandom_range(1, 15)), rd);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      expect_launch("rand", 1'b0);
    end

    repeat (80) @(negedge clk);
    check("end_frames", 64'(bus.frame_count), 64'(m_frames));
    check("end_mon_starts", 64'(mon_starts), 64'(m_frames));
    check("end_timeout_sticky", 64'(bus.timeout_err), 64'd1);

    // reset in the middle of a frame
    rd = {$urandom, $urandom};
    strobe(4'b1111, rd);
    expect_launch("pre_rst", 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    check("mrst_data",    bus.dac_data, {4{16'h8000}});
    check("mrst_start",   64'(bus.dac_start), 64'd0);
    check("mrst_frames",  64'(bus.frame_count), 64'd0);
    check("mrst_drops",   64'(bus.drop_count), 64'd0);
    check("mrst_timeout", 64'(bus.timeout_err), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
